// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage. Owns the PC, reads a combinational word-addressed ROM,
// and presents one instruction at a time to decode through a valid/ready output register.
// Optional build macro FETCH_UNIT_STATS_EN adds saturating fetch_cnt / stall_cnt outputs.
module fetch_unit #(
   parameter logic [15:0] RESET_PC = 16'h0000,
   parameter logic [15:0] PC_STEP  = 16'd1,
   localparam int unsigned PC_W    = 16,
   localparam int unsigned INSTR_W = 64
`ifdef FETCH_UNIT_STATS_EN
   ,
   localparam int unsigned CNT_W   = 32
`endif
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               start,
   input  logic               halt,
   input  logic               br_valid,
   input  logic [PC_W-1:0]    br_target,
   output logic [PC_W-1:0]    imem_a,
   input  logic [INSTR_W-1:0] imem_rd,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [INSTR_W-1:0] out_instr,
   output logic [PC_W-1:0]    out_pc,
`ifdef FETCH_UNIT_STATS_EN
   output logic [CNT_W-1:0]   fetch_cnt,
   output logic [CNT_W-1:0]   stall_cnt,
`endif
   output logic               busy
);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] RUN    = 2'd1;
   localparam logic [1:0] HALTED = 2'd2;

   logic [1:0]         state_q, state_d;
   logic               busy_q, busy_d;
   logic [PC_W-1:0]    pc_q, pc_d;
   logic               out_valid_q, out_valid_d;
   logic [INSTR_W-1:0] out_instr_q, out_instr_d;
   logic [PC_W-1:0]    out_pc_q, out_pc_d;
   logic               fetch_c;
   logic               transfer_c;

   // Fetch only in RUN, never during a redirect or halt, and only when the output slot frees up.
   assign fetch_c    = (state_q == RUN) && !halt && !br_valid && (!out_valid_q || out_ready);
   assign transfer_c = out_valid_q && out_ready;

   // FSM state register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         busy_q  <= busy_d;
      end
   end

   // Next-state logic; a redirect freezes the FSM for that cycle.
   always_comb begin
      state_d = state_q;
      if (!br_valid) begin
         case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (halt)  state_d = HALTED;
            HALTED:  if (start) state_d = RUN;
            default: state_d = IDLE;
         endcase
      end
      busy_d = (state_d == RUN);
   end

   // Datapath next values: redirect > fetch > drain.
   always_comb begin
      pc_d        = pc_q;
      out_valid_d = out_valid_q;
      out_instr_d = out_instr_q;
      out_pc_d    = out_pc_q;
      if (br_valid) begin
         pc_d        = br_target;
         out_valid_d = 1'b0;
      end else if (fetch_c) begin
         out_instr_d = imem_rd;
         out_pc_d    = pc_q;
         out_valid_d = 1'b1;
         pc_d        = PC_W'(pc_q + PC_STEP);
      end else if (transfer_c) begin
         out_valid_d = 1'b0;
      end
   end

   // PC and output register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pc_q        <= RESET_PC;
         out_valid_q <= 1'b0;
         out_instr_q <= '0;
         out_pc_q    <= '0;
      end else begin
         pc_q        <= pc_d;
         out_valid_q <= out_valid_d;
         out_instr_q <= out_instr_d;
         out_pc_q    <= out_pc_d;
      end
   end

   assign imem_a    = pc_q;
   assign out_valid = out_valid_q;
   assign out_instr = out_instr_q;
   assign out_pc    = out_pc_q;
   assign busy      = busy_q;

`ifdef FETCH_UNIT_STATS_EN
   logic [CNT_W-1:0] fetch_cnt_q, fetch_cnt_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

   // Saturating event counters.
   always_comb begin
      fetch_cnt_d = fetch_cnt_q;
      stall_cnt_d = stall_cnt_q;
      if (fetch_c && (fetch_cnt_q != '1)) fetch_cnt_d = CNT_W'(fetch_cnt_q + CNT_W'(1));
      if (out_valid_q && !out_ready && (stall_cnt_q != '1)) stall_cnt_d = CNT_W'(stall_cnt_q + CNT_W'(1));
   end

   // Counter registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         fetch_cnt_q <= '0;
         stall_cnt_q <= '0;
      end else begin
         fetch_cnt_q <= fetch_cnt_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign fetch_cnt = fetch_cnt_q;
   assign stall_cnt = stall_cnt_q;
`endif

endmodule
